// File: rtl/vco_adc_pkg.sv
// vco_adc_pkg: shared constants and types for the VCO ADC phase back-end
package vco_adc_pkg;
    localparam int NPHASE = 16;
    localparam int IDX_W = 5;
    localparam logic [NPHASE-1:0] PHASE_REF = 16'h5555;
    typedef logic [IDX_W-1:0] phase_idx_t;
endpackage

// File: rtl/phase_idx_decode.sv
// phase_idx_decode: thermometer ring code (after reference XOR) to phase index plus legality flag
module phase_idx_decode
    import vco_adc_pkg::*;
(
    input  logic [NPHASE-1:0] i_x,
    output phase_idx_t        o_idx,
    output logic              o_legal
);
    localparam logic [NPHASE-1:0] ONE = NPHASE'(1);
    phase_idx_t        w_ones;
    logic [NPHASE-1:0] w_inv;
    always_comb begin
        w_ones = '0;
        for (int i = 0; i < NPHASE; i++) w_ones = w_ones + phase_idx_t'(i_x[i]);
    end
    assign w_inv = ~i_x;
    // ones-from-MSB means the complement is a low mask; otherwise x itself must be a low mask
    assign o_legal = i_x[NPHASE-1] ? ((w_inv & (w_inv + ONE)) == '0) : ((i_x & (i_x + ONE)) == '0);
    assign o_idx = i_x[NPHASE-1] ? w_ones : phase_idx_t'(0) - w_ones;
endmodule

// File: rtl/vco_phase_decoder.sv
// vco_phase_decoder: synchronizes ring phases, differences the phase index and decimates the counts
module vco_phase_decoder
    import vco_adc_pkg::*;
#(
    parameter int DECIM       = 16,
    parameter int OUT_W       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [NPHASE-1:0] phases_i,
    output logic [IDX_W-1:0]  delta_o,
    output logic              delta_valid_o,
    output logic [OUT_W-1:0]  sum_o,
    output logic              sum_valid_o,
    output logic              code_err_o,
    output logic [7:0]        err_cnt_o
);
    localparam int CNT_W = $clog2(DECIM);

    if (OUT_W < $clog2(DECIM*31+1)) begin : g_bad_width
        $error("OUT_W too narrow for DECIM");
    end

    logic [SYNC_STAGES-1:0][NPHASE-1:0] r_sync;
    logic [SYNC_STAGES:0]               r_live;
    phase_idx_t                         r_idx, r_idx_prev, w_idx, w_delta;
    logic                               r_bad, r_prime, w_legal, w_active, w_valid, w_last;
    logic [CNT_W-1:0]                   r_cnt;
    logic [OUT_W-1:0]                   r_acc, w_acc_next;

    phase_idx_decode u_dec (
        .i_x     (r_sync[SYNC_STAGES-1] ^ PHASE_REF),
        .o_idx   (w_idx),
        .o_legal (w_legal)
    );

    // conversion only counts once every pipeline stage holds a sample taken while enabled
    assign w_active   = en_i & (&r_live);
    assign w_valid    = w_active & r_prime;
    assign w_delta    = r_idx - r_idx_prev;
    assign w_last     = r_cnt == CNT_W'(DECIM-1);
    assign w_acc_next = r_acc + OUT_W'(w_delta);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync        <= '0;
            r_live        <= '0;
            r_idx         <= '0;
            r_idx_prev    <= '0;
            r_bad         <= 1'b0;
            r_prime       <= 1'b0;
            r_cnt         <= '0;
            r_acc         <= '0;
            delta_o       <= '0;
            delta_valid_o <= 1'b0;
            sum_o         <= '0;
            sum_valid_o   <= 1'b0;
            code_err_o    <= 1'b0;
            err_cnt_o     <= '0;
        end else begin
            r_sync        <= {r_sync[SYNC_STAGES-2:0], phases_i};
            r_live        <= {r_live[SYNC_STAGES-1:0], en_i};
            r_idx         <= w_legal ? w_idx : r_idx;
            r_bad         <= ~w_legal;
            r_idx_prev    <= r_idx;
            r_prime       <= w_active;
            code_err_o    <= w_active & r_bad;
            delta_valid_o <= w_valid;
            sum_valid_o   <= w_valid & w_last;
            if (w_active & r_bad & ~&err_cnt_o) err_cnt_o <= err_cnt_o + 8'd1;
            if (w_valid) delta_o <= w_delta;
            if (!w_active) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_valid) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                r_acc <= w_last ? '0 : w_acc_next;
                if (w_last) sum_o <= w_acc_next;
            end
        end
    end
endmodule

// File: tb/tb_vco_phase_decoder.sv
// tb_vco_phase_decoder: random and directed stimulus checked against a sample-history reference model
module tb_vco_phase_decoder;
    localparam int DECIM = 16;
    localparam int OUT_W = 12;

    logic             clk, rst, en_i;
    logic [15:0]      phases_i;
    logic [4:0]       delta_o;
    logic             delta_valid_o, sum_valid_o, code_err_o;
    logic [OUT_W-1:0] sum_o;
    logic [7:0]       err_cnt_o;

    vco_phase_decoder #(.DECIM(DECIM), .OUT_W(OUT_W), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .phases_i      (phases_i),
        .delta_o       (delta_o),
        .delta_valid_o (delta_valid_o),
        .sum_o         (sum_o),
        .sum_valid_o   (sum_valid_o),
        .code_err_o    (code_err_o),
        .err_cnt_o     (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total, bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // reference: history of decoded samples (newest first) and of enable per edge
    int m_idx_q[$], m_bad_q[$], m_en_q[$];
    int m_cnt, m_acc, m_sum, m_err, m_delta;
    bit m_prime, e_dv, e_sv, e_ce;

    function automatic logic [15:0] ring_code(input int k);
        logic [15:0] ones = 16'hFFFF;
        if (k == 0) return 16'h0000;
        if (k <= 16) return ~(ones >> k);
        return ones >> (k - 16);
    endfunction

    function automatic logic [15:0] phase_of(input int k);
        return ring_code(k % 32) ^ 16'h5555;
    endfunction

    task automatic model_reset();
        m_idx_q = '{0, 0, 0, 0, 0};
        m_bad_q = '{0, 0, 0, 0, 0};
        m_en_q  = '{0, 0, 0, 0};
        m_prime = 0; m_cnt = 0; m_acc = 0; m_sum = 0; m_err = 0; m_delta = 0;
        e_dv = 0; e_sv = 0; e_ce = 0;
    endtask

    task automatic model_step(input logic [15:0] ph, input logic en);
        logic [15:0] x;
        int k;
        bit legal, active;
        x = ph ^ 16'h5555;
        legal = 0;
        k = 0;
        for (int j = 0; j < 32; j++) if (ring_code(j) == x) begin legal = 1; k = j; end
        m_idx_q.push_front(legal ? k : m_idx_q[0]);
        m_bad_q.push_front(legal ? 0 : 1);
        m_en_q.push_front(en ? 1 : 0);
        void'(m_idx_q.pop_back());
        void'(m_bad_q.pop_back());
        void'(m_en_q.pop_back());
        active = m_en_q[0] == 1 && m_en_q[1] == 1 && m_en_q[2] == 1 && m_en_q[3] == 1;
        e_dv = 0; e_sv = 0; e_ce = 0;
        if (!active) begin
            m_prime = 0; m_cnt = 0; m_acc = 0;
        end else begin
            e_ce = m_bad_q[3] != 0;
            if (e_ce && m_err < 255) m_err++;
            if (!m_prime) m_prime = 1;
            else begin
                m_delta = (m_idx_q[3] - m_idx_q[4]) & 31;
                e_dv = 1;
                m_acc += m_delta;
                m_cnt++;
                if (m_cnt == DECIM) begin
                    m_sum = m_acc; e_sv = 1; m_acc = 0; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic [15:0] ph, input logic en, input logic r);
        @(negedge clk);
        phases_i = ph; en_i = en; rst = r;
        if (r) begin
            #1;
            check("rst_sum", sum_o, 0);
            check("rst_err_cnt", err_cnt_o, 0);
            check("rst_sum_valid", sum_valid_o, 0);
        end
        @(posedge clk);
        if (r) model_reset(); else model_step(ph, en);
        #1;
        check("delta_valid", delta_valid_o, e_dv);
        check("sum_valid", sum_valid_o, e_sv);
        check("code_err", code_err_o, e_ce);
        check("err_cnt", err_cnt_o, m_err);
        check("delta", delta_o, m_delta);
        check("sum", sum_o, m_sum);
    endtask

    int st, fv;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; en_i = 1'b0; phases_i = 16'h5555;
        model_reset();
        cyc(16'h5555, 0, 1);
        cyc(16'h5555, 0, 1);
        cyc(16'h5555, 0, 0);
        fv = -1;
        for (int i = 0; i < 40; i++) begin
            cyc(16'h5555, 1, 0);
            if (delta_valid_o && fv < 0) fv = i;
        end
        check("first_valid_cycle", fv, 4);
        st = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(phase_of(st), 1, 0);
            st = (st + 1) % 32;
        end
        for (int i = 0; i < 4; i++) cyc(phase_of(29), 1, 0);
        cyc(phase_of(31), 1, 0);
        cyc(phase_of(2), 1, 0);
        for (int i = 0; i < 5; i++) cyc(phase_of(7), 1, 0);
        for (int i = 0; i < 4; i++) cyc(phase_of(4), 1, 0);
        cyc(16'h5A55, 1, 0);
        for (int i = 0; i < 5; i++) cyc(phase_of(6), 1, 0);
        check("illegal_err_cnt", err_cnt_o, 1);
        st = 6;
        for (int i = 0; i < 14; i++) begin
            cyc(phase_of(st), 1, 0);
            st = (st + 3) % 32;
        end
        cyc(phase_of(st), 1, 1);
        for (int i = 0; i < 30; i++) begin
            cyc(phase_of(st), 1, 0);
            st = (st + 1) % 32;
        end
        for (int i = 0; i < 14; i++) begin
            cyc(phase_of(st), 1, 0);
            st = (st + 2) % 32;
        end
        cyc(phase_of(st), 0, 0);
        for (int i = 0; i < 30; i++) begin
            cyc(phase_of(st), 1, 0);
            st = (st + 1) % 32;
        end
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            st = (st + $urandom_range(0, 31)) % 32;
            if (r < 5) cyc(phase_of(st), 1, 1);
            else if (r < 25) cyc(phase_of(st), 0, 0);
            else if (r < 75) cyc(16'($urandom), 1, 0);
            else cyc(phase_of(st), 1, 0);
        end
        for (int i = 0; i < 305; i++) cyc(16'h5A55, 1, 0);
        check("err_saturated", err_cnt_o, 255);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
